// File: rtl/leaf_sched_pkg.sv
// Shared types and helpers for the leaf round-robin scheduler.
// Holds the FSM state encoding, the default sizing constants and the one-hot decoder.
package leaf_sched_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    localparam int N_REQ_DEF    = 15;
    localparam int MAX_HOLD_DEF = 16;

    // Inputs are assumed one-hot or all zero; zero decodes to index 0.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/leaf_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible request at or after 'start', wrapping.
// Eligible means requested and not masked off; 'valid' flags that a winner exists.
module rr_pick
    import leaf_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         mask,
    input  logic [$clog2(N_REQ)-1:0] start,
    output logic [N_REQ-1:0]         winner,
    output logic                     valid
);

    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0] eligible;
    logic [IW:0]      pos;

    assign eligible = req & mask;

    // One extra bit on pos keeps the wrap comparison exact for any N_REQ.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        pos    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, start} + (IW+1)'(i);
            if (pos >= (IW+1)'(N_REQ)) begin
                pos = pos - (IW+1)'(N_REQ);
            end
            if (!valid && eligible[pos[IW-1:0]]) begin
                winner[pos[IW-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_rr_scheduler.sv
// Round-robin owner of the shared resource for the generated leaf instances.
// One registered one-hot grant, released by done, request drop, or the hold limit.
module leaf_rr_scheduler
    import leaf_sched_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         done_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_HOLD + 1);

    state_t           state;
    state_t           state_nxt;

    logic [IW-1:0]    last_winner;
    logic [IW-1:0]    lw_nxt;
    logic [IW-1:0]    start_idx;
    logic [CW-1:0]    hold_cnt;
    logic [CW-1:0]    cnt_nxt;

    logic [N_REQ-1:0] pick_mask;
    logic [N_REQ-1:0] pick_oh;
    logic             pick_vld;

    logic [N_REQ-1:0] gnt_nxt;
    logic [IW-1:0]    idx_nxt;
    logic             busy_nxt;
    logic             tmo_nxt;

    logic             owner_done;
    logic             owner_req;
    logic             hold_expired;
    logic             rel;

    // last_winner always equals the current owner while OWNED, so the search starts just past it.
    assign start_idx = (last_winner == IW'(N_REQ - 1)) ? '0 : last_winner + 1'b1;

    // The owner is masked out of its own release search; it comes back only via IDLE.
    assign pick_mask = (state == S_OWNED) ? ~gnt_o : '1;

    assign owner_done   = |(done_i & gnt_o);
    assign owner_req    = |(req_i & gnt_o);
    assign hold_expired = (hold_cnt == CW'(MAX_HOLD - 1));
    assign rel          = owner_done | ~owner_req | hold_expired;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (req_i),
        .mask   (pick_mask),
        .start  (start_idx),
        .winner (pick_oh),
        .valid  (pick_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_OWNED;
                end
            end
            S_OWNED: begin
                if (rel && !pick_vld) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt  = gnt_o;
        idx_nxt  = gnt_idx_o;
        busy_nxt = busy_o;
        tmo_nxt  = 1'b0;
        lw_nxt   = last_winner;
        cnt_nxt  = hold_cnt;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_nxt  = pick_oh;
                    idx_nxt  = IW'(onehot_to_idx(32'(pick_oh)));
                    busy_nxt = 1'b1;
                    lw_nxt   = IW'(onehot_to_idx(32'(pick_oh)));
                    cnt_nxt  = '0;
                end
            end
            S_OWNED: begin
                cnt_nxt = (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
                if (rel) begin
                    // A done in the expiry cycle counts as a normal release, not a timeout.
                    tmo_nxt = hold_expired && !owner_done;
                    if (pick_vld) begin
                        gnt_nxt  = pick_oh;
                        idx_nxt  = IW'(onehot_to_idx(32'(pick_oh)));
                        busy_nxt = 1'b1;
                        lw_nxt   = IW'(onehot_to_idx(32'(pick_oh)));
                        cnt_nxt  = '0;
                    end else begin
                        gnt_nxt  = '0;
                        idx_nxt  = '0;
                        busy_nxt = 1'b0;
                        cnt_nxt  = '0;
                    end
                end
            end
            default: begin
                gnt_nxt  = '0;
                idx_nxt  = '0;
                busy_nxt = 1'b0;
                cnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            busy_o      <= 1'b0;
            timeout_o   <= 1'b0;
            last_winner <= IW'(N_REQ - 1);
            hold_cnt    <= '0;
        end else begin
            gnt_o       <= gnt_nxt;
            gnt_idx_o   <= idx_nxt;
            busy_o      <= busy_nxt;
            timeout_o   <= tmo_nxt;
            last_winner <= lw_nxt;
            hold_cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_leaf_rr_scheduler.sv
// Bench for leaf_rr_scheduler: vector table, directed corner sequences and a randomized run
// checked against an owner/last-winner reference model.
`timescale 1ns/1ps
module tb_leaf_rr_scheduler;

    localparam int N  = 15;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] done_i = '0;
    logic [N-1:0] gnt_o;
    logic [3:0]   gnt_idx_o;
    logic         busy_o;
    logic         timeout_o;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 idle), last granted index, cycles held so far.
    int   m_owner;
    int   m_last;
    int   m_hold;
    logic m_tmo;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] gnt;
        logic [3:0]   idx;
        logic         busy;
        logic         tmo;
    } vec_t;

    vec_t tbl[13];

    always #5 clk = ~clk;

    leaf_rr_scheduler #(
        .N_REQ    (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_i),
        .done_i    (done_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] g, input logic [3:0] idx,
                              input logic b, input logic t);
        check($sformatf("%s.gnt", tag), 32'(gnt_o), 32'(g));
        check($sformatf("%s.idx", tag), 32'(gnt_idx_o), 32'(idx));
        check($sformatf("%s.busy", tag), 32'(busy_o), 32'(b));
        check($sformatf("%s.tmo", tag), 32'(timeout_o), 32'(t));
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_hold  = 0;
        m_tmo   = 1'b0;
    endfunction

    function automatic int search(input logic [N-1:0] r, input int excl);
        for (int off = 1; off <= N; off++) begin
            int i;
            i = (m_last + off) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    function automatic void model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
        int  w;
        bit  by_done;
        bit  expired;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            w = search(r, -1);
            if (w >= 0) begin
                m_owner = w; m_last = w; m_hold = 0;
            end
        end else begin
            by_done = d[m_owner];
            expired = (m_hold == MH - 1);
            if (by_done || !r[m_owner] || expired) begin
                m_tmo = expired && !by_done;
                w = search(r, m_owner);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_hold = 0;
                end else begin
                    m_owner = -1; m_hold = 0;
                end
            end else begin
                m_hold++;
            end
        end
    endfunction

    task automatic check_model(input string tag);
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        check_outs(tag, g, (m_owner >= 0) ? 4'(m_owner) : 4'd0, m_owner >= 0, m_tmo);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        req_i  = r;
        done_i = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req_i  = '0;
        done_i = '0;
        repeat (2) @(posedge clk);
        #2;
        check_outs("reset", '0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [N-1:0] rr;
        logic [N-1:0] dd;

        tbl[0]  = '{15'h0001, 15'h0000, 15'h0001, 4'd0, 1'b1, 1'b0};
        tbl[1]  = '{15'h0001, 15'h0001, 15'h0000, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{15'h0000, 15'h0000, 15'h0000, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{15'h0088, 15'h0000, 15'h0008, 4'd3, 1'b1, 1'b0};
        tbl[4]  = '{15'h0088, 15'h0080, 15'h0008, 4'd3, 1'b1, 1'b0};
        tbl[5]  = '{15'h0088, 15'h0008, 15'h0080, 4'd7, 1'b1, 1'b0};
        tbl[6]  = '{15'h0080, 15'h0000, 15'h0080, 4'd7, 1'b1, 1'b0};
        tbl[7]  = '{15'h0000, 15'h0000, 15'h0000, 4'd0, 1'b0, 1'b0};
        tbl[8]  = '{15'h0200, 15'h0000, 15'h0200, 4'd9, 1'b1, 1'b0};
        tbl[9]  = '{15'h0200, 15'h0200, 15'h0000, 4'd0, 1'b0, 1'b0};
        tbl[10] = '{15'h0200, 15'h0000, 15'h0200, 4'd9, 1'b1, 1'b0};
        tbl[11] = '{15'h0200, 15'h0000, 15'h0200, 4'd9, 1'b1, 1'b0};
        tbl[12] = '{15'h0000, 15'h0000, 15'h0000, 4'd0, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].req, tbl[i].done);
            check_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].busy, tbl[i].tmo);
        end

        // Full round robin, each owner releasing one cycle after its grant.
        do_reset();
        step(15'h7FFF, '0);
        check_outs("rr_first", 15'h0001, 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            step(15'h7FFF, N'(1) << k);
            check_outs($sformatf("rr%0d", k), N'(1) << ((k + 1) % N), 4'((k + 1) % N), 1'b1, 1'b0);
        end

        // Owner 3 never releases: held 16 cycles, then timeout hands over to 5.
        do_reset();
        step(15'h0028, '0);
        check_outs("to_grant", 15'h0008, 4'd3, 1'b1, 1'b0);
        for (int c = 1; c < MH; c++) begin
            step(15'h0028, '0);
            check($sformatf("to_hold%0d.gnt", c), 32'(gnt_o), 32'h0008);
            check($sformatf("to_hold%0d.tmo", c), 32'(timeout_o), 32'h0);
        end
        step(15'h0028, '0);
        check_outs("to_fire", 15'h0020, 4'd5, 1'b1, 1'b1);
        step(15'h0020, '0);
        check_outs("to_after", 15'h0020, 4'd5, 1'b1, 1'b0);

        // done in the expiry cycle takes precedence over the timeout.
        do_reset();
        step(15'h0028, '0);
        for (int c = 1; c < MH; c++) step(15'h0028, '0);
        check_outs("dt_pre", 15'h0008, 4'd3, 1'b1, 1'b0);
        step(15'h0028, 15'h0008);
        check_outs("dt_rel", 15'h0020, 4'd5, 1'b1, 1'b0);

        // Asynchronous reset while 12 owns, then 0 wins first.
        do_reset();
        step(15'h1000, '0);
        check_outs("ar_own", 15'h1000, 4'd12, 1'b1, 1'b0);
        req_i = 15'h1001;
        #3;
        rst_n = 1'b0;
        #1;
        check_outs("ar_async", '0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        #1;
        check_outs("ar_rel", '0, 4'd0, 1'b0, 1'b0);
        step(15'h1001, '0);
        check_outs("ar_first", 15'h0001, 4'd0, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        rr = '0;
        for (int n = 0; n < 600; n++) begin
            rr = rr ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0 && m_owner >= 0) begin
                dd = '0;
                dd[m_owner] = 1'b1;
            end else begin
                dd = N'($urandom & $urandom & $urandom);
            end
            step(rr, dd);
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/leaf_rr_scheduler.md
# leaf_rr_scheduler

Round-robin scheduler that shares one resource among the 15 leaf instances (inst_0 … inst_14) of a generated root module. It accepts per-leaf request and done lines, issues a one-hot grant, and enforces a maximum hold time so that a stuck leaf cannot starve the others. It sits in the root module beside the leaf instances and is the only block that drives their grant lines.

## Interface
- N_REQ, 15, number of requesters; valid range 2..32.
- MAX_HOLD, 16, maximum cycles a grant may be held before it is revoked; valid range 2..255.
- clk  in  1  single clock; all state is updated on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_i  in  N_REQ  per-leaf request; level-sensitive; held until the leaf is served.
- done_i  in  N_REQ  per-leaf release pulse; ignored unless that leaf holds the grant.
- gnt_o  out  N_REQ  one-hot grant, or all zero; registered.
- gnt_idx_o  out  $clog2(N_REQ)  index of the current owner; 0 when idle; registered.
- busy_o  out  1  high while any grant is active; registered.
- timeout_o  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- FSM with two states:
  - IDLE: no owner.
  - OWNED: exactly one gnt_o bit is set.
- Arbitration:
  - The search starts at last_winner+1 and wraps from N_REQ-1 to 0.
  - The first set req_i bit wins.
  - last_winner updates on every grant.
- Transitions from IDLE:
  - IDLE -> OWNED when any req_i bit is set.
- Transitions from OWNED, with owner k:
  - OWNED -> OWNED(new owner) on a release when another request is pending. There is no idle bubble.
  - OWNED -> IDLE on a release when no other request is pending.
  - A release is done_i[k]=1, req_i[k]=0, or the hold counter reaching MAX_HOLD-1.
- On a release, the owner k is excluded from the next search in that cycle. k can only win again if it is the sole requester.
- Hold counter:
  - Cleared on every new grant.
  - Increments each cycle while in OWNED.
  - Saturating width: $clog2(MAX_HOLD+1).
- Timeout: in the cycle the counter equals MAX_HOLD-1 with no done_i[k]:
  - The grant is revoked.
  - timeout_o pulses on the next edge, aligned with the gnt_o change.
- done_i on a non-owner bit has no effect.
- Multiple req_i bits set at once: only the round-robin winner is granted. The rest stay pending.

## Timing
- All outputs reset to 0 asynchronously. last_winner resets to N_REQ-1, so index 0 has first priority after reset.
- Grant latency: req_i seen at edge t while IDLE -> gnt_o set after edge t.
- Release latency: done_i seen at edge t -> old grant clears and the next grant, if any, is set after edge t (same cycle).
- done_i and the timeout in the same cycle: done_i wins and timeout_o stays 0.
- A grant is held for at most MAX_HOLD cycles.
- Reset asserted mid-grant: gnt_o, busy_o and timeout_o go to 0 immediately, the FSM goes to IDLE, and the hold counter clears.
- After rst_n deasserts, the first grant comes no earlier than one edge later.
- gnt_idx_o and busy_o always change on the same edge as gnt_o.

## Structure
- Package leaf_sched_pkg holds:
  - the state enum (S_IDLE, S_OWNED);
  - the default constants N_REQ_DEF=15 and MAX_HOLD_DEF=16;
  - a function that converts a one-hot vector to an index.
- Sub-module rr_pick is purely combinational. Inputs: req, mask and a start index. Outputs: a one-hot winner and a valid flag.
- rr_pick is instantiated once. The top level owns the FSM, the hold counter and the output registers.

## Test plan
- Reset, then req_i=15'h0001 -> gnt_o=15'h0001, gnt_idx_o=0 and busy_o=1 one edge later. Pulse done_i[0] -> all outputs 0 on the next edge.
- req_i=15'h7FFF held, each owner pulses done one cycle after its grant -> grants go 0,1,…,14,0 with no idle cycle between them.
- Owner 3 never releases, with MAX_HOLD=16 -> the grant lasts exactly 16 cycles, timeout_o pulses once, and the grant moves to the next pending requester (5, if req_i=bits 3 and 5).
- done_i[3] and the timeout in the same cycle -> timeout_o stays 0 and the grant moves normally. done_i[7] while 3 owns the grant -> no change.
- Sole requester 9 releases while still requesting -> 9 is granted again on the next edge. Owner drops req_i[9] with no done -> released on the next edge.
- rst_n pulled low while 12 owns the grant -> outputs are 0 without waiting for a clock. After release, with req_i=bits 12 and 0 -> 0 is granted first.
